// File: rtl/jtkicker_pkg.sv
// Shared constants for the Kicker object line buffer: bank geometry, transparent pixel,
// line_ok state encodings and the read-address helper.
package jtkicker_pkg;

    localparam int OBJ_DEPTH       = 256;
    localparam int OBJ_AW          = 8;
    localparam int OBJ_TRANSPARENT = 0;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    // Flip mirrors the line; the offset wraps inside 8 bits so it never reaches bit 8.
    function automatic logic [OBJ_AW-1:0] objReadAddr(
        input logic [OBJ_AW-1:0] hpos,
        input logic              flipScreen,
        input logic [OBJ_AW-1:0] offset
    );
        return (flipScreen ? ~hpos : hpos) + offset;
    endfunction

endpackage

// File: rtl/jtkicker_objbuf_ram.sv
// One 256-entry line bank: port A is the draw port, port B reads and erases in the same cycle.
// With JTKICKER_OBJBUF_PRIO_EN defined, port A also exposes its read data for read-before-write.
module jtkicker_objbuf_ram
    import jtkicker_pkg::*;
#(
    parameter int PW = 4
)(
    input  logic              clk_i,
    input  logic              a_we_i,
    input  logic [OBJ_AW-1:0] a_addr_i,
    input  logic [PW-1:0]     a_din_i,
`ifdef JTKICKER_OBJBUF_PRIO_EN
    output logic [PW-1:0]     a_dout_o,
`endif
    input  logic              b_en_i,
    input  logic [OBJ_AW-1:0] b_addr_i,
    output logic [PW-1:0]     b_dout_o
);

    logic [PW-1:0] mem_q [OBJ_DEPTH];

`ifdef JTKICKER_OBJBUF_PRIO_EN
    assign a_dout_o = mem_q[a_addr_i];
`endif
    assign b_dout_o = mem_q[b_addr_i];

    // The two ports always serve different roles of the double buffer, so their addresses never meet.
    always_ff @(posedge clk_i) begin
        if (b_en_i) begin
            mem_q[b_addr_i] <= PW'(OBJ_TRANSPARENT);
        end
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_din_i;
        end
    end

endmodule

// File: rtl/jtkicker_objbuf.sv
// Double-buffered object line buffer: one bank is drawn while the other is scanned and erased.
// Define JTKICKER_OBJBUF_PRIO_EN for first-drawn-wins priority (writes accepted every other clk).
module jtkicker_objbuf
    import jtkicker_pkg::*;
#(
    parameter logic [7:0] HOFFSET = 8'd0,
    parameter int         PW      = 4
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          hinit,
    input  logic [8:0]    hdump,
    input  logic          flip,
    input  logic          wr_en,
    input  logic [7:0]    wr_x,
    input  logic [PW-1:0] wr_pxl,
    output logic [PW-1:0] pxl,
    output logic          line_ok
);

    logic          sel_q, sel_d;
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pxl_q, pxl_d;

    logic          swap;
    logic          rdEn;
    logic [7:0]    rdAddr;
    logic [PW-1:0] rdData0, rdData1, rdData;
    logic          wrDo;
    logic          wrBank;
    logic [7:0]    wrAddr;
    logic [PW-1:0] wrData;
    logic          unusedHdump;

    assign swap        = pxl_cen & hinit;
    assign rdEn        = pxl_cen & ~rst;
    assign rdAddr      = objReadAddr(hdump[7:0], flip, HOFFSET);
    assign rdData      = sel_q ? rdData0 : rdData1;
    assign unusedHdump = hdump[8];

`ifdef JTKICKER_OBJBUF_PRIO_EN
    logic          pend_q, pend_d;
    logic          pendBank_q, pendBank_d;
    logic [7:0]    pendX_q, pendX_d;
    logic [PW-1:0] pendPxl_q, pendPxl_d;
    logic [PW-1:0] cur0, cur1, curPxl;

    assign curPxl = pendBank_q ? cur1 : cur0;

    // A write is captured with the bank current at its strobe, then committed next clk only onto a blank spot.
    always_comb begin
        pend_d     = 1'b0;
        pendBank_d = pendBank_q;
        pendX_d    = pendX_q;
        pendPxl_d  = pendPxl_q;
        if (!pend_q && wr_en && wr_pxl != PW'(OBJ_TRANSPARENT)) begin
            pend_d     = 1'b1;
            pendBank_d = sel_q;
            pendX_d    = wr_x;
            pendPxl_d  = wr_pxl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= 1'b0;
            pendBank_q <= 1'b0;
            pendX_q    <= '0;
            pendPxl_q  <= '0;
        end else begin
            pend_q     <= pend_d;
            pendBank_q <= pendBank_d;
            pendX_q    <= pendX_d;
            pendPxl_q  <= pendPxl_d;
        end
    end

    assign wrDo   = pend_q & ~rst & (curPxl == PW'(OBJ_TRANSPARENT));
    assign wrBank = pendBank_q;
    assign wrAddr = pendX_q;
    assign wrData = pendPxl_q;
`else
    assign wrDo   = wr_en & ~rst & (wr_pxl != PW'(OBJ_TRANSPARENT));
    assign wrBank = sel_q;
    assign wrAddr = wr_x;
    assign wrData = wr_pxl;
`endif

    jtkicker_objbuf_ram #(.PW(PW)) u_bank0 (
        .clk_i    (clk),
        .a_we_i   (wrDo & ~wrBank),
        .a_addr_i (wrAddr),
        .a_din_i  (wrData),
`ifdef JTKICKER_OBJBUF_PRIO_EN
        .a_dout_o (cur0),
`endif
        .b_en_i   (rdEn & sel_q),
        .b_addr_i (rdAddr),
        .b_dout_o (rdData0)
    );

    jtkicker_objbuf_ram #(.PW(PW)) u_bank1 (
        .clk_i    (clk),
        .a_we_i   (wrDo & wrBank),
        .a_addr_i (wrAddr),
        .a_din_i  (wrData),
`ifdef JTKICKER_OBJBUF_PRIO_EN
        .a_dout_o (cur1),
`endif
        .b_en_i   (rdEn & ~sel_q),
        .b_addr_i (rdAddr),
        .b_dout_o (rdData1)
    );

    // Two swaps guarantee both banks were scanned (and so erased) before output is trusted.
    always_comb begin
        sel_d   = sel_q ^ swap;
        state_d = state_q;
        if (swap) begin
            case (state_q)
                ST_INIT: state_d = ST_ONE;
                ST_ONE:  state_d = ST_VALID;
                default: state_d = ST_VALID;
            endcase
        end
        pxl_d = pxl_q;
        if (pxl_cen) begin
            pxl_d = (state_q == ST_VALID) ? rdData : PW'(OBJ_TRANSPARENT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= 1'b0;
            state_q <= ST_INIT;
            pxl_q   <= '0;
        end else begin
            sel_q   <= sel_d;
            state_q <= state_d;
            pxl_q   <= pxl_d;
        end
    end

    assign pxl     = pxl_q;
    assign line_ok = (state_q == ST_VALID);

endmodule
